enc4to2_reg: RTL and testbench
==============================

Name: enc4to2_reg

Overview:
- Registered 4-to-2 priority encoder: the encode side of the team's 2-to-4 decoder.
- Accepts a 4-bit one-hot word D[3:0] over a valid/ready handshake and returns the 2-bit index X[1:0] one cycle later.
- Flags any input that is not one-hot, and optionally counts those errors.
- Sits between a decoded select bus and any consumer that needs the compact binary code back.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter (used only when ENC4TO2_ERR_CNT_EN is defined).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  D holds a word to encode.
- in_ready  out  1  block can accept a word this cycle.
- D  in  4  decoded word D[3:0]; D3 has the highest priority.
- out_valid  out  1  X/err hold an encoded result.
- out_ready  in  1  consumer takes the result this cycle.
- X  out  2  encoded index (X1 is the MSB).
- err  out  1  the captured D was not exactly one-hot.
- err_cnt  out  ERR_CNT_W  count of accepted error words.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Asserting rst_n low immediately forces:
  - state = EMPTY
  - out_valid = 0, X = 2'b00, err = 0, err_cnt = 0
- in_ready after reset: in_ready is 1 from reset onward.
- Reset mid-operation: any held result is discarded. No partial transfer is completed.
- Encoding (combinational, inside the sub-module):
  - X = index of the highest set bit of D: D3 -> 11, D2 -> 10, D1 -> 01, D0 -> 00.
  - D = 0000 -> X = 00.
  - err = 1 when popcount(D) != 1. This covers 0000 and any multi-hot word.
- State machine, states EMPTY and FULL:
  - in_ready = (state == EMPTY) || out_ready. This is combinational and has no dependency on in_valid.
  - accept = in_valid && in_ready.
  - EMPTY: on accept, register X/err, set out_valid = 1, go to FULL. Otherwise stay in EMPTY.
  - FULL with out_ready && accept: load the new result, stay in FULL, keep out_valid = 1. This is back-to-back throughput of 1 word per cycle.
  - FULL with out_ready && !accept: out_valid = 0, go to EMPTY. X/err keep their last value.
  - FULL with !out_ready: hold X/err/out_valid stable. in_ready = 0, and D is ignored.
- Latency: exactly 1 cycle from accept to out_valid = 1 with the matching X.
- Output registers: X and err change only on accept.
- out_valid in EMPTY: out_valid is never 1 in EMPTY.

Optional Feature:
- Macro: ENC4TO2_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on every accept whose D has err = 1.
  - The count saturates at 2^ERR_CNT_W-1 and does not wrap.
  - The count is cleared only by rst_n.
  - The update is in the same cycle as the output register load.
- Undefined:
  - The counter logic is not built.
  - err_cnt is tied to 0, so the port list stays identical in both builds.

Decomposition:
- Package enc4to2_pkg holds:
  - typedef enum state_t {EMPTY, FULL}
  - constant IN_W = 4
  - constant OUT_W = 2
- One sub-module, enc4to2_prio: purely combinational. Maps D to {X, err}. Reusable by the verification model.
- enc4to2_reg holds the FSM, the output registers and the optional counter.

Test Plan:
- Reset and sweep:
  - Stimulus: assert rst_n = 0 mid-transfer. Then release it and apply D = 0001, 0010, 0100, 1000 with out_ready = 1.
  - Required response: out_valid = 0 and X = 00 during reset. After release, X = 00, 01, 10, 11 with err = 0, each appearing 1 cycle after its accept.
- Invalid codes:
  - Stimulus: D = 0000, then D = 0110, then D = 1011.
  - Required response: X = 00/err = 1, then X = 10/err = 1, then X = 11/err = 1.
  - With the macro: err_cnt = 3 afterwards. Without the macro: err_cnt = 0.
- Backpressure:
  - Stimulus: accept D = 0100. Then hold out_ready = 0 for 5 cycles while D toggles.
  - Required response: in_ready = 0 and X = 10 stay stable throughout. Raising out_ready drains the result and in_ready returns to 1.
- Back-to-back:
  - Stimulus: in_valid = 1 and out_ready = 1 continuously, with D = 1000, 0001, 0010 on consecutive cycles.
  - Required response: out_valid stays 1 and X = 11, 00, 01 on consecutive cycles, with no bubble.
- Counter saturation:
  - Setup: ERR_CNT_W = 2, macro defined.
  - Stimulus: 5 accepted words with D = 0000.
  - Required response: err_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/enc4to2_pkg.sv
// Shared types and widths for the registered 4-to-2 priority encoder.
package enc4to2_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 2;

endpackage

// File: rtl/enc4to2_prio.sv
// Combinational 4-to-2 priority encoder: highest set bit wins, err on any non-one-hot word.
module enc4to2_prio
  import enc4to2_pkg::*;
(
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] x,
  output logic             err
);

  always_comb begin
    x = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (d[i]) x = OUT_W'(i);
    end
    err = ($countones(d) != 1);
  end

endmodule

// File: rtl/enc4to2_reg.sv
// Registered 4-to-2 priority encoder with valid/ready handshake.
// Optional saturating error counter enabled by defining ENC4TO2_ERR_CNT_EN.
module enc4to2_reg
  import enc4to2_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      D,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     X,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t           state, state_d;
  logic             accept;
  logic [OUT_W-1:0] x_enc;
  logic             err_enc;

  enc4to2_prio u_prio (
    .d   (D),
    .x   (x_enc),
    .err (err_enc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_d;
  end

  always_comb begin
    in_ready = (state == EMPTY) || out_ready;
    accept   = in_valid && in_ready;
    state_d  = state;
    case (state)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // X/err only move on accept so the last result survives a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X   <= '0;
      err <= 1'b0;
    end else if (accept) begin
      X   <= x_enc;
      err <= err_enc;
    end
  end

`ifdef ENC4TO2_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (accept && err_enc && cnt_q != '1)  cnt_q <= cnt_q + ERR_CNT_W'(1);
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_enc4to2_reg.sv
// Self-checking bench for enc4to2_reg against a transaction-level model of the handshake.
module tb_enc4to2_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] D = 4'b0000;
  logic       in_ready, out_valid, err, in_ready2, out_valid2, err2;
  logic [1:0] X, X2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  // Model: one result slot plus an unbounded count of accepted error words.
  bit m_valid;
  int m_x;
  bit m_err;
  int m_cnt;

  enc4to2_reg #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .X(X), .err(err), .err_cnt(err_cnt)
  );

  enc4to2_reg #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .D(D),
    .out_valid(out_valid2), .out_ready(out_ready), .X(X2), .err(err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang, need finish");
    $fatal(1, "watchdog");
  end

  function automatic int hi_index(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) if (w[i]) return i;
    return 0;
  endfunction

  function automatic int exp_cnt(input int limit);
`ifdef ENC4TO2_ERR_CNT_EN
    return (m_cnt > limit) ? limit : m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_ready();
    return !m_valid || out_ready;
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit acc;
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      m_valid = 1'b1;
      m_x     = hi_index(D);
      m_err   = ($countones(D) != 1);
      if (m_err) m_cnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_x = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; D = 4'b0000;
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; D = 4'b0100; out_ready = 1'b0;
    tick();
    D = 4'b0000;
    tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || X !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b X=%b err=%b, need valid=0 X=00 err=0", out_valid, X, err);
    end
    checks++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d, need 0/0", err_cnt, err_cnt2);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got valid=%b ready=%b, need valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 4'b0001 << i;
      in_valid = 1'b1; D = w;
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(X) !== m_x || err !== 1'b0 || m_x != i) begin
        errors++;
        $display("FAIL sweep_%0d: got valid=%b X=%0d err=%b, need valid=1 X=%0d err=0", i, out_valid, X, err, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_invalid();
    logic [3:0] words [3];
    int         want  [3];
    words = '{4'b0000, 4'b0110, 4'b1011};
    want  = '{0, 2, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; D = words[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(X) !== want[i] || err !== 1'b1) begin
        errors++;
        $display("FAIL invalid_%0d: got valid=%b X=%0d err=%b, need valid=1 X=%0d err=1", i, out_valid, X, err, want[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (int'(err_cnt) !== exp_cnt(255)) begin
      errors++;
      $display("FAIL invalid_cnt: got %0d, need %0d", err_cnt, exp_cnt(255));
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; D = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      D = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || X !== 2'b10 || err !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_%0d: got ready=%b valid=%b X=%b err=%b, need ready=0 valid=1 X=10 err=0",
                 i, in_ready, out_valid, X, err);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || X !== 2'b10) begin
      errors++;
      $display("FAIL drain: got valid=%b ready=%b X=%b, need valid=0 ready=1 X=10", out_valid, in_ready, X);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [3];
    int         want  [3];
    words = '{4'b1000, 4'b0001, 4'b0010};
    want  = '{3, 0, 1};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      D = words[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(X) !== want[i] || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got valid=%b X=%0d ready=%b, need valid=1 X=%0d ready=1", i, out_valid, X, in_ready, want[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      D         = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (in_ready !== exp_ready() || in_ready2 !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready_%0d: got %b/%b, need %b", i, in_ready, in_ready2, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid || int'(X) !== m_x || err !== m_err ||
          out_valid2 !== m_valid || int'(X2) !== m_x || err2 !== m_err) begin
        errors++;
        $display("FAIL rand_out_%0d: got valid=%b X=%0d err=%b, need valid=%b X=%0d err=%b",
                 i, out_valid, X, err, m_valid, m_x, m_err);
      end
      checks++;
      if (int'(err_cnt) !== exp_cnt(255) || int'(err_cnt2) !== exp_cnt(3)) begin
        errors++;
        $display("FAIL rand_cnt_%0d: got %0d/%0d, need %0d/%0d", i, err_cnt, err_cnt2, exp_cnt(255), exp_cnt(3));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    int want [5];
`ifdef ENC4TO2_ERR_CNT_EN
    want = '{1, 2, 3, 3, 3};
`else
    want = '{0, 0, 0, 0, 0};
`endif
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; D = 4'b0000;
      tick();
      checks++;
      if (int'(err_cnt2) !== want[i] || int'(err_cnt2) !== exp_cnt(3)) begin
        errors++;
        $display("FAIL saturate_%0d: got %0d, need %0d", i, err_cnt2, want[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
